// File: rtl/pulse_gate_pkg.sv
// -----------------------------------------------------------------------------
// pulse_gate_pkg
// Shared types and helpers for the toggle-encoded logic cell model.
//   gate_mode_e  : logic function selector (AND / OR / XOR / MAJ)
//   gate_state_e : window state (IDLE / ACCUM / INVALID)
//   gate_eval()  : evaluates a logic function over an arrival mask
//   DLY_CNT_W / HOLD_CNT_W : widths of the output-delay and hold-window ranges
// -----------------------------------------------------------------------------
package pulse_gate_pkg;

    localparam int DLY_CNT_W  = 4;
    localparam int HOLD_CNT_W = 4;
    localparam int MAX_IN     = 8;

    typedef enum logic [1:0] {
        AND = 2'd0,
        OR  = 2'd1,
        XOR = 2'd2,
        MAJ = 2'd3
    } gate_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        INVALID = 2'd2
    } gate_state_e;

    // Result of the logic function over the first n bits of mask.
    // An empty mask is false in every mode (n is always at least 2).
    function automatic logic gate_eval(gate_mode_e mode, logic [MAX_IN-1:0] mask, int n);
        int   cnt;
        logic res;
        cnt = 0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (i < n && mask[i]) begin
                cnt = cnt + 1;
            end
        end
        case (mode)
            AND:     res = (cnt == n);
            OR:      res = (cnt != 0);
            XOR:     res = cnt[0];
            MAJ:     res = ((2 * cnt) > n);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pulse_logic_gate_if.sv
// -----------------------------------------------------------------------------
// pulse_logic_gate_if
// Bundle of the logic cell's pulse and status signals.
//   in_tgl   : N_IN toggle-encoded input pulses   (master -> slave)
//   eval_tgl : toggle-encoded evaluate strobe      (master -> slave)
//   err_clr  : one-cycle request to leave INVALID  (master -> slave)
//   out_tgl  : toggle-encoded result               (slave -> master)
//   err      : high while in INVALID               (slave -> master)
//   viol     : one-cycle hold-violation pulse      (slave -> master)
//   viol_cnt : saturating hold-violation count     (slave -> master)
// The master modport is the stimulus side, the slave modport the gate.
// -----------------------------------------------------------------------------
interface pulse_logic_gate_if #(
    parameter int N_IN  = 2,
    parameter int CNT_W = 8
);
    logic [N_IN-1:0]  in_tgl;
    logic             eval_tgl;
    logic             err_clr;
    logic             out_tgl;
    logic             err;
    logic             viol;
    logic [CNT_W-1:0] viol_cnt;

    modport master (
        output in_tgl,
        output eval_tgl,
        output err_clr,
        input  out_tgl,
        input  err,
        input  viol,
        input  viol_cnt
    );

    modport slave (
        input  in_tgl,
        input  eval_tgl,
        input  err_clr,
        output out_tgl,
        output err,
        output viol,
        output viol_cnt
    );
endinterface

// File: rtl/toggle_edge_det.sv
// -----------------------------------------------------------------------------
// toggle_edge_det
// Converts a toggle-encoded line into a one-cycle event flag.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   i_tgl : toggle-encoded input (every level change is one pulse)
//   o_evt : high in the cycle where i_tgl differs from its registered copy
// -----------------------------------------------------------------------------
module toggle_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tgl,
    output logic o_evt
);
    logic r_prev;

    // Reset preloads the copy from the live line so that releasing reset never
    // looks like a pulse, whatever level the line happens to sit at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= i_tgl;
        end else begin
            r_prev <= i_tgl;
        end
    end

    assign o_evt = i_tgl ^ r_prev;

endmodule

// File: rtl/pulse_logic_gate.sv
// -----------------------------------------------------------------------------
// pulse_logic_gate
// Cycle-based model of a toggle-encoded logic cell with N_IN inputs, a
// selectable logic function, a programmable output delay and a hold monitor.
//   clk      : sole clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : pulse_logic_gate_if.slave
//              in_tgl / eval_tgl / err_clr in, out_tgl / err / viol / viol_cnt out
// Parameters: N_IN (2..8), MODE (0 AND,1 OR,2 XOR,3 MAJ), OUT_DLY (1..15),
//             HOLD_CYC (0..15), CNT_W (violation counter width).
// -----------------------------------------------------------------------------
module pulse_logic_gate
    import pulse_gate_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int MODE     = 0,
    parameter int OUT_DLY  = 2,
    parameter int HOLD_CYC = 1,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pulse_logic_gate_if.slave bus
);

    localparam gate_mode_e                 LP_MODE    = gate_mode_e'(MODE[1:0]);
    localparam int                         LP_DLY_LEN = int'(OUT_DLY[DLY_CNT_W-1:0]);
    localparam logic [HOLD_CNT_W-1:0]      LP_HOLD    = HOLD_CYC[HOLD_CNT_W-1:0];

    // ---------------------------------------------------------------- events
    logic [N_IN-1:0] w_in_evt;
    logic            w_eval_evt;
    logic            w_in_any;

    for (genvar g = 0; g < N_IN; g++) begin : g_in_det
        toggle_edge_det u_in_det (
            .clk   (clk),
            .rst_n (rst_n),
            .i_tgl (bus.in_tgl[g]),
            .o_evt (w_in_evt[g])
        );
    end

    toggle_edge_det u_eval_det (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tgl (bus.eval_tgl),
        .o_evt (w_eval_evt)
    );

    assign w_in_any = |w_in_evt;

    // ------------------------------------------------------------ window FSM
    gate_state_e       r_state;
    gate_state_e       w_state_nxt;
    logic [N_IN-1:0]   r_arr;
    logic [N_IN-1:0]   w_arr_nxt;
    logic [MAX_IN-1:0] w_arr_ext;
    logic              w_result;
    logic              w_sched;

    assign w_arr_ext = MAX_IN'(r_arr);
    assign w_result  = gate_eval(LP_MODE, w_arr_ext, N_IN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_arr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_arr   <= w_arr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arr_nxt   = r_arr;
        w_sched     = 1'b0;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_eval_evt) begin
                    // Inputs arriving with the evaluate open the next window.
                    w_sched     = w_result;
                    w_arr_nxt   = w_in_evt;
                    w_state_nxt = (w_in_any) ? ACCUM : IDLE;
                end else if (|(w_in_evt & r_arr)) begin
                    w_state_nxt = INVALID;
                end else begin
                    w_arr_nxt   = r_arr | w_in_evt;
                    w_state_nxt = (|(r_arr | w_in_evt)) ? ACCUM : IDLE;
                end
            end
            INVALID: begin
                // Clear takes priority over any input event in the same cycle.
                if (bus.err_clr) begin
                    w_arr_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_arr_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- hold monitor
    // r_hold_cnt counts the remaining cycles of the window that follows an
    // evaluate; the evaluate cycle itself is covered combinationally. The
    // monitor watches raw events, so it keeps running while INVALID.
    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic                  w_viol;
    logic                  r_viol;
    logic [CNT_W-1:0]      r_viol_cnt;

    assign w_viol = w_in_any & (w_eval_evt | (r_hold_cnt != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_viol     <= 1'b0;
            r_viol_cnt <= '0;
        end else begin
            if (w_eval_evt) begin
                r_hold_cnt <= LP_HOLD;
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - HOLD_CNT_W'(1);
            end
            r_viol <= w_viol;
            if (w_viol && (r_viol_cnt != '1)) begin
                r_viol_cnt <= r_viol_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------ delay line
    // One bit per cycle of latency so overlapping evaluates each keep their
    // own toggle; the output flop flips when a scheduled bit falls off the end.
    logic [LP_DLY_LEN-1:0] r_dly;
    logic                  r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
            r_out <= 1'b0;
        end else begin
            r_dly[0] <= w_sched;
            for (int i = 1; i < LP_DLY_LEN; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
            r_out <= r_out ^ r_dly[LP_DLY_LEN-1];
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.out_tgl  = r_out;
    assign bus.err      = (r_state == INVALID);
    assign bus.viol     = r_viol;
    assign bus.viol_cnt = r_viol_cnt;

endmodule

// File: doc/pulse_logic_gate.md
# pulse_logic_gate

Parametrised cycle-based model of a toggle-encoded (pulse-per-edge) logic cell: N inputs, a clock-like evaluate strobe, a selectable logic function, a programmable output delay and hold-window checking. It is the successor to the fixed two-input AND cell model. It adds N inputs, four logic modes, a counted hold-violation monitor and a recoverable invalid state. It sits in integration benches between stimulus generators and the VCD assertion checker, and replaces per-gate hand-written models.

## Interface
- N_IN, 2: number of data inputs (2..8).
- MODE, 0: logic function; 0 AND, 1 OR, 2 XOR (odd parity), 3 MAJ (strictly more than N_IN/2 arrivals).
- OUT_DLY, 2: evaluate-to-output latency in cycles (1..15).
- HOLD_CYC, 1: hold window in cycles after an evaluate event (0..15).
- CNT_W, 8: width of the violation counter.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_tgl  in  N_IN  toggle-encoded input pulses; each level change of bit i is one pulse on input i.
- eval_tgl  in  1  toggle-encoded evaluate pulse, the gate's own clock pulse.
- err_clr  in  1  single-cycle request to leave INVALID.
- out_tgl  out  1  toggle-encoded result; toggles once per true evaluation.
- err  out  1  high while in INVALID.
- viol  out  1  one-cycle pulse per hold violation.
- viol_cnt  out  CNT_W  saturating count of hold violations.

## Operation
- Event detection: previous in_tgl and eval_tgl are registered. An event in cycle k is a sampled value that differs from the registered value at posedge k. Reset loads the registered copies from the live inputs, so reset release produces no event.
- Arrival mask arr[N_IN-1:0] records input events since the last evaluate.
- States:
  - IDLE: arr==0.
  - ACCUM: arr!=0.
  - INVALID: a second event on an input whose arr bit is already set in the same window; the reference model's X state.
- IDLE/ACCUM transitions:
  - Input event sets its arr bit; a double arrival goes to INVALID.
  - An evaluate event computes f(arr) per MODE. If true, a toggle is scheduled. arr is cleared and the state goes to IDLE.
  - An evaluate event with arr==0 is legal and yields false in every mode.
- INVALID:
  - Input and evaluate events are ignored; no toggles are scheduled. Toggles already in the delay line still drain.
  - err=1.
  - err_clr clears arr and goes to IDLE in the next cycle.
- Input event in the same cycle as an evaluate event: it belongs to the next window. It is not part of the current evaluation, it sets its arr bit after the clear, and it is a hold violation.
- Hold monitor:
  - Any input event within HOLD_CYC cycles after an evaluate event (the same cycle counts as offset 0) raises viol for one cycle and increments viol_cnt, which saturates at all-ones.
  - With HOLD_CYC=0, only the same-cycle case is checked.
  - Multiple inputs violating in one cycle count as one.
  - The monitor is also active in INVALID.
- Output delay line: a shift register of OUT_DLY bits. Evaluate events closer together than OUT_DLY cycles each produce an independent toggle; none are lost or merged.
- Reset state: all outputs 0, state IDLE, arr 0, delay line empty, hold timer expired.

## Timing
- Evaluate event at posedge k with a true result: out_tgl changes after posedge k+OUT_DLY.
- err rises after the posedge of the offending event and falls after the posedge following err_clr.
- viol is asserted in the cycle after the violating event is detected; viol_cnt updates on the same edge as viol.
- Asynchronous reset mid-operation empties the delay line immediately; scheduled toggles are dropped.
- err_clr and an input event in the same cycle: the clear wins and the event is discarded.

## Structure
- Package pulse_gate_pkg:
  - enum gate_mode_e {AND, OR, XOR, MAJ};
  - enum gate_state_e {IDLE, ACCUM, INVALID};
  - pure function gate_eval(mode, mask, n) returning the logic result;
  - width constants for the delay and hold counters (4 bits).
- Sub-module toggle_edge_det, instantiated N_IN+1 times. It owns the registered previous value and the reset-time preload, and emits a one-cycle event.

## Test plan
- MODE=AND, N_IN=2, OUT_DLY=2: toggle in[0] at cycle 10, in[1] at 12, eval at 15 -> out_tgl toggles after cycle 17; viol_cnt=0.
- MODE=MAJ, N_IN=3: arrivals on in[0] and in[2] only, then eval -> one toggle. A later window with only in[1] -> no toggle.
- HOLD_CYC=2: eval at cycle 20, in[1] toggles at 21 -> viol pulse, viol_cnt=1, and in[1] counted in the next window. in[1] at cycle 23 -> no violation.
- Double arrival on in[0] before eval -> err=1 and subsequent evals produce no output. err_clr -> err=0, IDLE, normal AND operation resumes.
- OUT_DLY=4: eval events at cycles 30 and 31, both true -> toggles after cycles 34 and 35. rst_n low at cycle 32 -> neither toggle appears, and out_tgl=0 from reset assertion.
- CNT_W=2: five hold violations -> viol_cnt stops at 3 and viol pulses 5 times.
